unitate_de_fetch: RTL
=====================

# unitate_de_fetch

Instruction fetch stage of the RISC-8 core, directly upstream of `unitate_de_control`. It owns the program counter and issues one instruction-memory read at a time. It latches the returned 16-bit instruction into an instruction register and presents it, with its 4-bit opcode field split out, to the control unit until it is consumed. It also handles branch/jump redirects from the execute side and stops fetching on a HALT instruction.

## Interface
Parameters:
- `PC_W`, default 8: program-counter and instruction-address width.
- `INSTR_W`, default 16: instruction width. Format is [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- `RESET_PC`, default 8'h00: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: read request to instruction memory.
- `imem_addr`, output, PC_W: read address. Equals the PC while `imem_req`=1.
- `imem_rdata`, input, INSTR_W: read data, qualified by `imem_valid`.
- `imem_valid`, input, 1: read data valid. One pulse per request, arriving no earlier than the cycle after `imem_req` rises.
- `stall`, input, 1: downstream is not ready to consume the presented instruction.
- `redirect`, input, 1: a branch was taken or a jump executed; load `redirect_pc`.
- `redirect_pc`, input, PC_W: redirect target.
- `instr_valid`, output, 1: `instr`, `opcode` and `instr_pc` are valid.
- `instr`, output, INSTR_W: instruction register.
- `opcode`, output, 4: `instr[15:12]`, feeding `unitate_de_control.opcode`.
- `instr_pc`, output, PC_W: address the presented instruction was fetched from.
- `halted`, output, 1: a HALT has been fetched and consumed.

## Operation
- States are IDLE, FETCH, OUT and HALT. Reset forces IDLE.
- **IDLE:** all outputs are deasserted. The block moves to FETCH unconditionally on the first edge after reset release.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=PC, both held stable until `imem_valid`.
  - If `redirect`=1 while waiting: set the `discard` flag and store `redirect_pc` into the pending target. If several redirects arrive before the response, the last one wins.
  - On `imem_valid` with `discard`=0: `instr`←`imem_rdata`, `instr_pc`←PC, PC←PC+1, go to OUT.
  - On `imem_valid` with `discard`=1: drop the data, PC←pending target, clear `discard`, stay in FETCH. The new request starts the next cycle.
  - If `imem_valid` and `redirect` occur in the same cycle, the redirect wins: the data is dropped and PC←`redirect_pc`.
- **OUT:** `instr_valid`=1 and `imem_req`=0.
  - `redirect`=1: the presented instruction counts as consumed (it is the branch/jump). PC←`redirect_pc`, go to FETCH. `redirect` takes priority over `stall`.
  - `stall`=1 with `redirect`=0: hold all outputs unchanged.
  - `stall`=0 with `redirect`=0: the instruction is consumed.
    - If it is HALT (opcode 4'b1111 and imm 8'hFF), go to HALT.
    - Otherwise go to FETCH.
- **HALT:** `halted`=1, `instr_valid`=0, `imem_req`=0. `redirect` is ignored. Only `rst_n` exits this state.
- **PC arithmetic:** modulo 2^PC_W, so 8'hFF+1 wraps to 8'h00 with no flag. `redirect_pc` is used unmodified.
- **Reset values:** PC=`RESET_PC`; `imem_req`=0; `imem_addr`=`RESET_PC`; `instr`=0; `opcode`=0; `instr_pc`=0; `instr_valid`=0; `halted`=0; `discard`=0.
- **Reset mid-fetch:** instruction memory shares `rst_n`, so no stale response arrives after reset. The block does not filter stale responses.

## Timing
- Cycle 0 is the first edge after reset release: IDLE→FETCH.
- Cycle 1: `imem_req`=1.
- Fetch-to-present latency: `instr_valid` rises on the edge after the cycle in which `imem_valid`=1 is sampled.
- Throughput, zero-wait memory (`imem_valid` the cycle after `imem_req`) and no stall: one instruction every 3 cycles (FETCH, FETCH, OUT).
- A redirect in OUT makes `imem_req` assert with `imem_addr`=`redirect_pc` on the next cycle.
- `opcode` is a wire slice of `instr`, so it adds no extra latency.
- All outputs come from registers or the state decode. There is no combinational path from `imem_rdata` to any output.

## Structure
- Package `risc8_pkg` holds:
  - `PC_W` and `INSTR_W` defaults;
  - opcode field bit positions;
  - `OP_HALT` = 4'b1111 and `IMM_HALT` = 8'hFF;
  - the state enum.
- `unitate_de_control` also imports `risc8_pkg`.
- One sub-module, `contor_program`: PC register with asynchronous reset to `RESET_PC`, an increment enable, and a load with `redirect_pc`. It owns the wrap rule.

## Test plan
- **Reset and first fetch:** release `rst_n` with `RESET_PC`=8'h00 and memory returning 16'h1234 one cycle after request → `imem_req` at cycle 1 with address 8'h00; `instr_valid`=1 at cycle 3 with `opcode`=4'h1 and `instr_pc`=8'h00.
- **Stall hold:** present an instruction, drive `stall`=1 for 4 cycles → `instr`, `instr_pc` and `instr_valid` stay constant and `imem_req`=0. Release `stall` → next fetch is at address 8'h01.
- **Redirect in OUT:** with `stall`=1, drive `redirect`=1 and `redirect_pc`=8'h40 → next cycle `imem_req`=1 with `imem_addr`=8'h40.
- **Redirect during FETCH:** memory latency 3 cycles, `redirect` to 8'h20 during the wait → the response is discarded, `instr_valid` stays 0, and the next request is to 8'h20.
- **PC wrap:** `redirect` to 8'hFF, let that instruction be consumed → next request address is 8'h00.
- **HALT:** memory returns 16'hF0FF, consumed with `stall`=0 → `halted`=1 and `imem_req` stays 0 despite `redirect` pulses. Asserting `rst_n`=0 → `halted`=0.

Source files
------------

// File: rtl/risc8_pkg.sv
// risc8_pkg: shared definitions for the RISC-8 front end.
// Holds the default address/instruction widths, the instruction field
// positions, the HALT encoding and the fetch state enum. Both
// unitate_de_fetch and unitate_de_control import this package.
package risc8_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;

    // Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [7:0] IMM_HALT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // HALT is recognised by opcode and imm only; rd/rs are don't-care.
    function automatic logic is_halt(input logic [15:0] ins);
        return (ins[OPC_MSB:OPC_LSB] == OP_HALT) && (ins[IMM_MSB:IMM_LSB] == IMM_HALT);
    endfunction

endpackage

// File: rtl/unitate_de_fetch_contor_program.sv
// contor_program: program counter register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (PC <- RESET_PC)
//   inc_en      - advance PC by one (wraps modulo 2^PC_W)
//   load_en     - load load_pc unmodified; wins over inc_en
//   load_pc     - load target
//   pc          - current PC
module contor_program #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc_q <= RESET_PC;
        else if (load_en) pc_q <= load_pc;
        else if (inc_en)  pc_q <= pc_q + 1'b1;  // natural wrap, no carry out
    end

    assign pc = pc_q;

endmodule

// File: rtl/unitate_de_fetch.sv
// unitate_de_fetch: instruction fetch stage of the RISC-8 core.
// Issues one instruction-memory read at a time, latches the response into
// the instruction register and presents it to unitate_de_control until it
// is consumed. Handles execute-side redirects and stops on HALT.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   imem_req/imem_addr        - read request and address (addr = PC)
//   imem_rdata/imem_valid     - read response, one valid pulse per request
//   stall                     - downstream not ready to consume
//   redirect/redirect_pc      - taken branch / jump target
//   instr_valid/instr/opcode/instr_pc - presented instruction
//   halted                    - HALT fetched and consumed
module unitate_de_fetch
    import risc8_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic               discard_q, discard_d;
    logic [PC_W-1:0]    pend_q, pend_d;

    logic               pc_inc, pc_load, capture;
    logic [PC_W-1:0]    pc_load_val, pc;

    contor_program #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (pc_inc),
        .load_en (pc_load),
        .load_pc (pc_load_val),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            discard_q  <= 1'b0;
            pend_q     <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            pend_q    <= pend_d;
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        pend_d      = pend_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = redirect_pc;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    if (redirect) begin
                        // A redirect coinciding with the response beats it.
                        pc_load   = 1'b1;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        // Response belongs to a squashed path; refetch at target.
                        pc_load     = 1'b1;
                        pc_load_val = pend_q;
                        discard_d   = 1'b0;
                    end else begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_OUT;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the response, so only
                    // remember the target; last redirect wins.
                    discard_d = 1'b1;
                    pend_d    = redirect_pc;
                end
            end
            ST_OUT: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    state_d = is_halt(instr_q) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state_q == ST_OUT);
    assign halted      = (state_q == ST_HALT);
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign instr_pc    = instr_pc_q;

endmodule
